// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, init ROM and helpers for the HD44780 write engine.
package lcd_pkg;

    localparam int TMR_W = 20;

    localparam logic [2:0] INIT_LEN = 3'd6;
    // Element 0 is sent first: function set x3, display on, clear, entry mode.
    localparam logic [5:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    typedef enum logic [2:0] {
        PWR_WAIT,
        LOAD,
        SETUP,
        EN_HI,
        HOLD,
        EXEC,
        IDLE
    } state_t;

    // Clear and home (0x01..0x03) need the long execution wait.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] data);
        return !rs && data[7:2] == 6'd0 && data != 8'd0;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter; done while the count sits at zero.
module lcd_timer
    import lcd_pkg::*;
#(
    parameter logic [TMR_W-1:0] RST_VAL = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            r_cnt <= RST_VAL;
        else if (load)
            r_cnt <= load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: autonomous HD44780 init plus valid/ready byte writer
// with setup, enable, hold and execution-wait timing.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP   = 750000,
    parameter int unsigned T_SETUP     = 3,
    parameter int unsigned T_EN        = 13,
    parameter int unsigned T_HOLD      = 3,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    input  logic       blon_en,
    output logic       init_done,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    state_t           r_state;
    logic [2:0]       r_idx;
    logic             w_done;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_accept;

    assign w_accept = in_valid && in_ready;
    assign lcd_rw   = 1'b0;

    // A state lasting N cycles loads N-1 on its entry edge.
    assign w_load = (r_state == LOAD) || (r_state == IDLE && w_accept) ||
                    (w_done && (r_state inside {SETUP, EN_HI, HOLD}));

    assign w_load_val = (r_state == SETUP) ? TMR_W'(T_EN - 1) :
                        (r_state == EN_HI) ? TMR_W'(T_HOLD - 1) :
                        (r_state == HOLD)  ? (is_long_wait(lcd_rs, lcd_data) ?
                                              TMR_W'(T_EXEC_LONG - 1) : TMR_W'(T_EXEC - 1)) :
                                             TMR_W'(T_SETUP - 1);

    lcd_timer #(
        .RST_VAL(TMR_W'(T_POWERUP - 1))
    ) u_timer (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .load         (w_load),
        .load_val     (w_load_val),
        .done         (w_done)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= PWR_WAIT;
            r_idx     <= 3'd0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
            lcd_on    <= 1'b0;
            lcd_blon  <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            lcd_on   <= 1'b1;
            lcd_blon <= blon_en;
            case (r_state)
                PWR_WAIT: if (w_done) r_state <= LOAD;
                LOAD: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= INIT_ROM[r_idx];
                    r_idx    <= r_idx + 3'd1;
                    r_state  <= SETUP;
                end
                SETUP: if (w_done) begin
                    lcd_en  <= 1'b1;
                    r_state <= EN_HI;
                end
                EN_HI: if (w_done) begin
                    lcd_en  <= 1'b0;
                    r_state <= HOLD;
                end
                HOLD: if (w_done) r_state <= EXEC;
                EXEC: if (w_done) begin
                    if (r_idx < INIT_LEN) begin
                        r_state <= LOAD;
                    end else begin
                        r_state   <= IDLE;
                        in_ready  <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                IDLE: if (w_accept) begin
                    in_ready <= 1'b0;
                    lcd_rs   <= in_rs;
                    lcd_data <= in_data;
                    r_state  <= SETUP;
                end
                default: r_state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl: directed self-checking bench for the HD44780 write engine
// using shortened timing parameters.
module tb_lcd_hd44780_ctrl;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       blon_en = 1'b0;
    logic       in_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rel = 0;
    int rb = 0;
    int fb = 0;

    logic       rw_seen = 1'b0;
    logic       unstable = 1'b0;
    logic       prev_en = 1'b0;
    logic [8:0] prev_val = 9'h0;
    int         q_rise[$];
    int         q_fall[$];
    logic [8:0] q_val[$];

    localparam logic [7:0] EXP_ROM [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    localparam int EXP_RISE [6] = '{23, 42, 61, 80, 99, 138};

    lcd_hd44780_ctrl #(
        .T_POWERUP(20), .T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_EXEC(10), .T_EXEC_LONG(30)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs        (in_rs),
        .in_data      (in_data),
        .blon_en      (blon_en),
        .init_done    (init_done),
        .lcd_on       (lcd_on),
        .lcd_blon     (lcd_blon),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_en       (lcd_en),
        .lcd_data     (lcd_data)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= cyc + 1;

    // Records every EN pulse as (rise edge, fall edge, rs:data) relative to reset release.
    always @(negedge clk_clk) begin
        if (lcd_rw) rw_seen = 1'b1;
        if (lcd_en && !prev_en) begin
            q_rise.push_back(cyc - rel);
            q_val.push_back({lcd_rs, lcd_data});
        end
        if (!lcd_en && prev_en) q_fall.push_back(cyc - rel);
        if (lcd_en && prev_en && {lcd_rs, lcd_data} != prev_val) unstable = 1'b1;
        prev_en  = lcd_en;
        prev_val = {lcd_rs, lcd_data};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int c);
        for (int i = 0; i < 400 && !in_ready; i++) @(negedge clk_clk);
        if (!in_ready) chk("ready_timeout", 0, 1);
        c = cyc - rel;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input logic keep, output int k);
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        for (int i = 0; i < 400 && !in_ready; i++) @(negedge clk_clk);
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(negedge clk_clk);
        k = cyc - rel;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic release_reset();
        reset_reset_n = 1'b1;
        rel = cyc;
        rb  = q_rise.size();
        fb  = q_fall.size();
    endtask

    task automatic check_init();
        int c;
        wait_ready(c);
        chk("init_ready_cyc", c, 154);
        chk("init_done", init_done, 1);
        chk("init_pulses", q_rise.size() - rb, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("init_val%0d", i), q_val[rb+i], {1'b0, EXP_ROM[i]});
            chk($sformatf("init_rise%0d", i), q_rise[rb+i], EXP_RISE[i]);
            chk($sformatf("init_width%0d", i), q_fall[fb+i] - q_rise[rb+i], 4);
        end
    endtask

    initial begin
        int k, c, k0, k1, k2, s;
        logic [7:0] seq_d [3] = '{8'h01, 8'h80, 8'h02};
        int seq_gap [3] = '{38, 18, 38};
        logic [7:0] str_d [3] = '{8'h48, 8'h49, 8'h21};

        repeat (3) @(negedge clk_clk);
        chk("reset_outputs", {in_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en, lcd_data}, 0);
        release_reset();
        @(negedge clk_clk);
        chk("lcd_on_first_edge", lcd_on, 1);
        chk("not_ready_in_init", in_ready, 0);
        check_init();

        send(1'b1, 8'h41, 1'b0, k);
        chk("data_on_accept", {lcd_rs, lcd_data}, 9'h141);
        chk("ready_low_after_accept", in_ready, 0);
        wait_ready(c);
        chk("data_ready_gap", c - k, 18);
        chk("data_en_delay", q_rise[rb+6] - k, 2);
        chk("data_en_width", q_fall[fb+6] - q_rise[rb+6], 4);
        chk("data_en_val", q_val[rb+6], 9'h141);

        for (int i = 0; i < 3; i++) begin
            send(1'b0, seq_d[i], 1'b0, k);
            wait_ready(c);
            chk($sformatf("cmd_gap_%0h", seq_d[i]), c - k, seq_gap[i]);
        end
        chk("hold_after_xfer", {lcd_rs, lcd_data}, 9'h002);

        s = q_rise.size();
        send(1'b1, str_d[0], 1'b1, k0);
        send(1'b1, str_d[1], 1'b1, k1);
        send(1'b1, str_d[2], 1'b0, k2);
        chk("stream_gap1", k1 - k0, 19);
        chk("stream_gap2", k2 - k1, 19);
        wait_ready(c);
        repeat (30) @(negedge clk_clk);
        chk("stream_pulses", q_rise.size() - s, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("stream_val%0d", i), q_val[s+i], {1'b1, str_d[i]});
        chk("stream_hold", {lcd_rs, lcd_data}, {1'b1, str_d[2]});

        send(1'b0, 8'h80, 1'b0, k);
        for (int i = 0; i < 50 && !lcd_en; i++) @(negedge clk_clk);
        chk("en_seen_before_reset", lcd_en, 1);
        #2 reset_reset_n = 1'b0;
        #1 chk("async_en_drop", lcd_en, 0);
        chk("async_reset_outputs", {in_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en, lcd_data}, 0);
        repeat (3) @(negedge clk_clk);
        chk("held_reset_outputs", {in_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en, lcd_data}, 0);
        release_reset();
        check_init();

        blon_en = 1'b1;
        chk("blon_latency_lo", lcd_blon, 0);
        @(negedge clk_clk);
        chk("blon_rise", lcd_blon, 1);
        blon_en = 1'b0;
        @(negedge clk_clk);
        chk("blon_fall", lcd_blon, 0);

        chk("rw_never_high", rw_seen, 0);
        chk("data_stable_during_en", unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
# lcd_hd44780_ctrl

Hardware HD44780 character-LCD write engine that sits directly downstream of the Nios II system and directly upstream of the DE2 LCD pins, replacing software bit-banging of LCD_RS/RW/EN/DATA. It runs the power-up initialisation sequence autonomously, then accepts command/data bytes over a valid/ready handshake. For each byte it generates HD44780-compliant setup, enable-pulse, hold and execution-wait timing.

## Interface
Parameters (all counts in clk_clk cycles at 50 MHz):
- T_POWERUP, 750000: wait after reset before first init command (15 ms)
- T_SETUP, 3: RS/DATA stable before EN rises
- T_EN, 13: EN high width
- T_HOLD, 3: EN low before execution wait starts
- T_EXEC, 2000: execution wait, normal instructions and data (40 us)
- T_EXEC_LONG, 82000: execution wait, clear/home (1.64 ms)

Ports:
- clk_clk  in  1  system clock, 50 MHz
- reset_reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  byte offered
- in_ready  out  1  engine idle and initialised; transfer on in_valid && in_ready
- in_rs  in  1  0 = instruction, 1 = character data
- in_data  in  8  byte to write
- blon_en  in  1  backlight request
- init_done  out  1  init sequence complete (sticky until reset)
- lcd_on  out  1  LCD power
- lcd_blon  out  1  backlight
- lcd_rs  out  1  register select
- lcd_rw  out  1  read/write, tied low (write-only)
- lcd_en  out  1  enable strobe
- lcd_data  out  8  LCD data bus

## Operation
- Reset values: in_ready=0, init_done=0, lcd_on=0, lcd_blon=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0x00.
- lcd_on is registered 1 from the first clock edge after reset release. lcd_blon is blon_en registered, with 1 cycle latency.
- States:
  - PWR_WAIT: count T_POWERUP, then go to LOAD.
  - LOAD: drive the next init ROM entry, then go to SETUP.
  - SETUP: T_SETUP cycles, then EN_HI.
  - EN_HI: T_EN cycles, then HOLD.
  - HOLD: T_HOLD cycles, then EXEC.
  - EXEC: T_EXEC or T_EXEC_LONG cycles, then LOAD while ROM entries remain, else IDLE.
  - IDLE: in_ready=1.
  - An accepted transfer in IDLE latches in_rs/in_data onto lcd_rs/lcd_data at the accept edge and enters SETUP.
- Init ROM (rs=0), in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. init_done sets on the first entry into IDLE.
- Long wait applies when rs=0 and data[7:2]==0 and data!=0 (0x01, 0x02, 0x03). Everything else, including all rs=1 bytes, uses T_EXEC.
- lcd_rs/lcd_data hold their value after the transfer until the next transfer.
- in_valid while not in_ready is ignored and never queued. in_rs/in_data are don't-care when in_valid=0.
- Reset asserted mid-operation clears all state immediately: lcd_en drops asynchronously and init restarts from PWR_WAIT on release.

## Timing
- Accept edge k: lcd_rs/lcd_data valid after edge k, and in_ready=0 after edge k.
- lcd_en rises at edge k+T_SETUP and falls at edge k+T_SETUP+T_EN.
- in_ready reasserts at edge k+T_SETUP+T_EN+T_HOLD+Texec, where Texec = T_EXEC or T_EXEC_LONG. Back-to-back transfers are possible on that edge.
- Init: first lcd_en rise at T_POWERUP+1+T_SETUP cycles after reset release (the +1 is the LOAD cycle). Each init entry takes 1+T_SETUP+T_EN+T_HOLD+Texec cycles.
- lcd_en is registered and glitch-free, and is never high outside EN_HI.

## Structure
- Package lcd_pkg holds:
  - state enum
  - init ROM constant array with its length (6)
  - command codes CMD_CLEAR=0x01, CMD_HOME=0x02
  - long-wait predicate function
- Sub-module lcd_timer: loadable down-counter, 20-bit (covers 750000). Ports: load, load_val, done; done is 1 when the count is 0.
- The FSM and the init index (3-bit) live in lcd_hd44780_ctrl.

## Test plan
Run with parameters T_POWERUP=20, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=30.
- Reset release → six EN pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with rs=0. Gap after 0x01 is 30 exec cycles, others 10. init_done and in_ready rise together after the last one; first EN rise at cycle 23.
- After init, write rs=1 data=0x41 → lcd_rs=1, lcd_data=0x41 on the accept edge. EN high for exactly 4 cycles starting 2 cycles after accept; in_ready back 18 cycles after accept.
- Write rs=0 0x01, then rs=0 0x80, then rs=0 0x02 → ready gaps of 38, 18 and 38 cycles respectively.
- Hold in_valid=1 continuously with a 3-byte stream → exactly 3 EN pulses, each byte accepted only when in_ready=1, with no drops or duplicates.
- Assert reset_reset_n=0 during EN_HI → lcd_en=0 immediately, all outputs at reset values. After release, the full init sequence repeats.
- Toggle blon_en → lcd_blon follows 1 cycle later. lcd_rw stays 0 throughout.
